// File: rtl/gate_reduce_pkg.sv
// Shared definitions for the pipelined reduction gate:
// op codes, base functions and tree-shape helpers.
package gate_reduce_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_RSV0 = 3'b110;
  localparam logic [2:0] OP_RSV1 = 3'b111;

  typedef enum logic [1:0] {
    BF_AND = 2'b00,
    BF_OR  = 2'b01,
    BF_XOR = 2'b10,
    BF_RSV = 2'b11
  } base_fn_e;

  function automatic base_fn_e base_fn(
    input logic [2:0] op
  );
    return base_fn_e'(op[2:1]);
  endfunction

  function automatic logic is_rsv(
    input logic [2:0] op
  );
    return op[2:1] == 2'b11;
  endfunction

  // Value that leaves the base function unchanged
  function automatic logic ident(
    input base_fn_e f
  );
    logic r;
    r = 1'b1;
    unique case (1'b1)
      (f == BF_OR),
      (f == BF_XOR): r = 1'b0;
      default:       r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic combine(
    input base_fn_e f,
    input logic     x,
    input logic     y
  );
    logic r;
    r = x & y;
    unique case (1'b1)
      (f == BF_OR):  r = x | y;
      (f == BF_XOR): r = x ^ y;
      default:       r = x & y;
    endcase
    return r;
  endfunction

  function automatic int clog_fanin(
    input int w,
    input int f
  );
    int     n;
    longint p;
    n = 0;
    p = 1;
    while (p < longint'(w)) begin
      p = p * longint'(f);
      n = n + 1;
    end
    return n;
  endfunction

  // Node count at the output of tree level k
  function automatic int level_width(
    input int w,
    input int f,
    input int k
  );
    int r;
    r = w;
    for (int i = 0; i < k; i++) begin
      r = (r + f - 1) / f;
    end
    return r;
  endfunction

endpackage

// File: rtl/gate_reduce_level.sv
// One registered level of the reduction tree.
// The final level also applies inversion and the reserved override.
module gate_reduce_level
  import gate_reduce_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int FANIN = 4,
  parameter bit FINAL = 1'b0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ce,
  input  logic                               vld_i,
  input  logic [IN_W-1:0]                    d_i,
  input  logic [2:0]                         op_i,
  input  logic                               rsv_i,
  output logic                               vld_o,
  output logic [(IN_W+FANIN-1)/FANIN-1:0]    d_o,
  output logic [2:0]                         op_o,
  output logic                               rsv_o
);

  localparam int OUT_W = (IN_W + FANIN - 1) / FANIN;
  localparam int PAD_W = OUT_W * FANIN;

  base_fn_e         fn;
  logic [PAD_W-1:0] pad;
  logic [OUT_W-1:0] red;
  logic [OUT_W-1:0] d_d;

  logic             vld_q;
  logic [OUT_W-1:0] d_q;
  logic [2:0]       op_q;
  logic             rsv_q;

  assign fn = base_fn(op_i);

  always_comb begin
    pad = {PAD_W{ident(fn)}};
    pad[IN_W-1:0] = d_i;
  end

  always_comb begin
    logic acc;
    red = '0;
    acc = 1'b0;
    for (int j = 0; j < OUT_W; j++) begin
      acc = ident(fn);
      for (int i = 0; i < FANIN; i++) begin
        acc = combine(fn, acc, pad[j*FANIN+i]);
      end
      red[j] = acc;
    end
  end

  always_comb begin
    d_d = red;
    if (FINAL) begin
      if (rsv_i) begin
        d_d = '0;
      end else begin
        d_d = red ^ {OUT_W{op_i[0]}};
      end
    end
  end

  // Payload only moves with a valid token, so bubbles hold ZN/ERR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      d_q   <= '0;
      op_q  <= '0;
      rsv_q <= 1'b0;
    end else if (ce) begin
      vld_q <= vld_i;
      if (vld_i) begin
        d_q   <= d_d;
        op_q  <= op_i;
        rsv_q <= rsv_i;
      end
    end
  end

  assign vld_o = vld_q;
  assign d_o   = d_q;
  assign op_o  = op_q;
  assign rsv_o = rsv_q;

endmodule

// File: rtl/gate_reduce_pipe.sv
// Pipelined N-input AND/OR/XOR reduction with optional inversion,
// built from a generate chain of registered FANIN-input levels.
module gate_reduce_pipe
  import gate_reduce_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int FANIN = 4
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             CE,
  input  logic             IVALID,
  input  logic [WIDTH-1:0] A,
  input  logic [2:0]       OP,
  output logic             OVALID,
  output logic             ZN,
  output logic             ERR
);

  localparam int NLVL = clog_fanin(WIDTH, FANIN);
  localparam int LAT  = (NLVL < 1) ? 1 : NLVL;

  for (genvar k = 0; k < LAT; k++) begin : g_lvl
    localparam int IW = level_width(WIDTH, FANIN, k);
    localparam int OW = level_width(WIDTH, FANIN, k + 1);

    logic          vld;
    logic [IW-1:0] d;
    logic [2:0]    op;
    logic          rsv;
    logic          vld_q;
    logic [OW-1:0] q;
    logic [2:0]    op_q;
    logic          rsv_q;

    if (k == 0) begin : g_in
      assign vld = IVALID;
      assign d   = A;
      assign op  = OP;
      assign rsv = is_rsv(OP);
    end else begin : g_chain
      assign vld = g_lvl[k-1].vld_q;
      assign d   = g_lvl[k-1].q;
      assign op  = g_lvl[k-1].op_q;
      assign rsv = g_lvl[k-1].rsv_q;
    end

    gate_reduce_level #(
      .IN_W  (IW),
      .FANIN (FANIN),
      .FINAL (k == LAT - 1)
    ) u_lvl (
      .clk   (CLK),
      .rst_n (RSTN),
      .ce    (CE),
      .vld_i (vld),
      .d_i   (d),
      .op_i  (op),
      .rsv_i (rsv),
      .vld_o (vld_q),
      .d_o   (q),
      .op_o  (op_q),
      .rsv_o (rsv_q)
    );
  end

  logic unused_op;
  assign unused_op = ^g_lvl[LAT-1].op_q;

  assign OVALID = g_lvl[LAT-1].vld_q;
  assign ZN     = g_lvl[LAT-1].q[0];
  assign ERR    = g_lvl[LAT-1].rsv_q;

endmodule

// File: tb/tb_gate_reduce_pipe.sv
// Directed-vector bench for gate_reduce_pipe at WIDTH 11, 13 and 1.
// Expected results are hand-computed in the vector table.
module tb_gate_reduce_pipe;
  import gate_reduce_pkg::*;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        CE;
  logic        IVALID;
  logic [2:0]  OP;
  logic [10:0] a11;
  logic [12:0] a13;
  logic [0:0]  a1;
  logic        ov11, zn11, er11;
  logic        ov13, zn13, er13;
  logic        ov1, zn1, er1;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  gate_reduce_pipe #(.WIDTH(11), .FANIN(4)) u11 (
    .CLK(CLK), .RSTN(RSTN), .CE(CE), .IVALID(IVALID),
    .A(a11), .OP(OP),
    .OVALID(ov11), .ZN(zn11), .ERR(er11)
  );

  gate_reduce_pipe #(.WIDTH(13), .FANIN(4)) u13 (
    .CLK(CLK), .RSTN(RSTN), .CE(CE), .IVALID(IVALID),
    .A(a13), .OP(OP),
    .OVALID(ov13), .ZN(zn13), .ERR(er13)
  );

  gate_reduce_pipe #(.WIDTH(1), .FANIN(4)) u1 (
    .CLK(CLK), .RSTN(RSTN), .CE(CE), .IVALID(IVALID),
    .A(a1), .OP(OP),
    .OVALID(ov1), .ZN(zn1), .ERR(er1)
  );

  typedef struct {
    logic [2:0]  op;
    logic [10:0] a11;
    logic [12:0] a13;
    logic        a1;
    logic        z11;
    logic        z13;
    logic        z1;
    logic        err;
  } vec_t;

  localparam int NV = 18;
  vec_t tv [NV];

  task automatic chk(
    input string    name,
    input int       idx,
    input logic [2:0] got,
    input logic [2:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got {ovalid,zn,err}=%b want %b",
               name, idx, got, exp);
    end
  endtask

  initial begin
    tv[0]  = '{OP_NAND, 11'h7FF, 13'h1FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{OP_NAND, 11'h7FE, 13'h1FFE, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tv[2]  = '{OP_AND,  11'h400, 13'h1FFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tv[3]  = '{OP_NAND, 11'h400, 13'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tv[4]  = '{OP_OR,   11'h400, 13'h1000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[5]  = '{OP_NOR,  11'h400, 13'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[6]  = '{OP_XOR,  11'h400, 13'h1001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[7]  = '{OP_XNOR, 11'h400, 13'h1000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[8]  = '{OP_XOR,  11'h000, 13'h1000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[9]  = '{OP_NOR,  11'h000, 13'h0001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[10] = '{OP_XOR,  11'h7FF, 13'h1FFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tv[11] = '{OP_XNOR, 11'h7FF, 13'h1FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[12] = '{OP_XOR,  11'h003, 13'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[13] = '{OP_RSV0, 11'h123, 13'h0ABC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[14] = '{OP_AND,  11'h7FF, 13'h1FFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tv[15] = '{OP_RSV1, 11'h000, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[16] = '{OP_AND,  11'h001, 13'h1FFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[17] = '{OP_XOR,  11'h007, 13'h0007, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    RSTN   = 1'b0;
    CE     = 1'b1;
    IVALID = 1'b0;
    OP     = OP_AND;
    a11    = '0;
    a13    = '0;
    a1     = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_w11", 0, {ov11, zn11, er11}, 3'b000);
    chk("reset_w13", 0, {ov13, zn13, er13}, 3'b000);
    chk("reset_w1",  0, {ov1,  zn1,  er1},  3'b000);
    RSTN = 1'b1;

    // Back-to-back stream; WIDTH=1 shows results one cycle earlier
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) begin
        IVALID = 1'b1;
        OP     = tv[i].op;
        a11    = tv[i].a11;
        a13    = tv[i].a13;
        a1     = tv[i].a1;
      end else begin
        IVALID = 1'b0;
      end
      @(posedge CLK);
      #1;
      if (i < NV) begin
        chk("w1", i, {ov1, zn1, er1}, {1'b1, tv[i].z1, tv[i].err});
      end else begin
        chk("w1_bubble", i, {ov1, zn1, er1},
            {1'b0, tv[NV-1].z1, tv[NV-1].err});
      end
      if (i > 0) begin
        chk("w11", i - 1, {ov11, zn11, er11},
            {1'b1, tv[i-1].z11, tv[i-1].err});
        chk("w13", i - 1, {ov13, zn13, er13},
            {1'b1, tv[i-1].z13, tv[i-1].err});
      end
    end
    @(posedge CLK);
    #1;
    chk("w11_bubble", NV, {ov11, zn11, er11},
        {1'b0, tv[NV-1].z11, tv[NV-1].err});
    chk("w13_bubble", NV, {ov13, zn13, er13},
        {1'b0, tv[NV-1].z13, tv[NV-1].err});

    // Clock-enable freeze with a reserved op offered while frozen
    IVALID = 1'b1;
    OP     = OP_AND;
    a11    = 11'h7FF;
    @(posedge CLK);
    #1;
    OP  = OP_NAND;
    a11 = 11'h7FF;
    @(posedge CLK);
    #1;
    chk("ce_t1", 0, {ov11, zn11, er11}, 3'b110);
    CE     = 1'b0;
    IVALID = 1'b1;
    OP     = OP_RSV0;
    a11    = 11'h000;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      chk("ce_hold", k, {ov11, zn11, er11}, 3'b110);
    end
    CE     = 1'b1;
    IVALID = 1'b0;
    @(posedge CLK);
    #1;
    chk("ce_t2", 0, {ov11, zn11, er11}, 3'b100);
    @(posedge CLK);
    #1;
    chk("ce_bubble", 0, {ov11, zn11, er11}, 3'b000);

    // Mid-cycle reset with two transactions in flight
    IVALID = 1'b1;
    OP     = OP_AND;
    a11    = 11'h7FF;
    a1     = 1'b1;
    @(posedge CLK);
    #1;
    OP  = OP_RSV0;
    a11 = 11'h000;
    @(posedge CLK);
    #1;
    chk("rst_pre", 0, {ov11, zn11, er11}, 3'b110);
    OP = OP_RSV1;
    #3;
    RSTN = 1'b0;
    #1;
    chk("rst_async_w11", 0, {ov11, zn11, er11}, 3'b000);
    chk("rst_async_w13", 0, {ov13, zn13, er13}, 3'b000);
    chk("rst_async_w1",  0, {ov1,  zn1,  er1},  3'b000);
    @(posedge CLK);
    #1;
    RSTN   = 1'b1;
    IVALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      chk("rst_flush_w11", k, {ov11, zn11, er11}, 3'b000);
      chk("rst_flush_w1",  k, {ov1,  zn1,  er1},  3'b000);
    end

    // Pipeline still usable after the flush
    IVALID = 1'b1;
    OP     = OP_XOR;
    a11    = 11'h001;
    @(posedge CLK);
    #1;
    IVALID = 1'b0;
    @(posedge CLK);
    #1;
    chk("post_rst", 0, {ov11, zn11, er11}, 3'b110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
